midi_message_parser: RTL and testbench
======================================

// Module: midi_message_parser
// PURPOSE
//  Assembles the raw MIDI byte stream from the UART receiver into complete channel
//  messages for the parameter/voice control stages, which consume message/message_ready.
//  Handles running status, interleaved real-time bytes, SysEx discard and optional
//  channel filtering. One message_ready pulse is produced per complete channel message.
// PARAMETERS
//  OMNI            1     1: accept all channels; 0: accept only CHANNEL
//  CHANNEL         0     4-bit channel accepted when OMNI=0
//  NOTE_ON_ZERO_OFF 1    1: NOTE_ON with velocity 0 is emitted as NOTE_OFF (vel 0)
// PORTS
//  clock_50_000_000  in   1   system clock
//  reset_l           in   1   synchronous, active-low reset
//  rx_byte           in   8   byte from UART receiver
//  rx_valid          in   1   rx_byte valid this cycle (1-cycle strobe per byte)
//  message           out  24  MIDI::message_t {message_type[3:0], channel[3:0],
//                             data_byte1[7:0], data_byte2[7:0]}
//  message_ready     out  1   1-cycle pulse: message holds a new complete message
//  framing_error     out  1   1-cycle pulse: data byte received with no running status
// BEHAVIOUR
//  Reset (reset_l=0 at clock edge): state=IDLE, running status cleared, message=0,
//   message_ready=0, framing_error=0. Reset mid-message discards the partial message.
//  Byte classes: status = bit7 set; data = bit7 clear; real-time = F8..FF.
//  Real-time bytes: ignored in every state; state, running status, partial data kept.
//  FSM states: IDLE, WAIT_D1, WAIT_D2, SYSEX.
//   Any channel status 80..EF (any state): store as running status; channel-filtered
//    status (OMNI=0, nibble!=CHANNEL) still stored but marked "drop"; -> WAIT_D1.
//    Partial message in progress is abandoned, no output.
//   F0: clear running status -> SYSEX. F1..F7: clear running status -> IDLE.
//   IDLE + data: discarded, framing_error pulses next cycle.
//   WAIT_D1 + data: latch d1. Types C (program change), D (channel pressure): message
//    complete with data_byte2=00, stay WAIT_D1. Other types -> WAIT_D2.
//   WAIT_D2 + data: latch d2, message complete -> WAIT_D1 (running status retained).
//   SYSEX + data: discarded, no framing_error. SYSEX exits only on status byte (F7->IDLE,
//    others per rules above).
//  Completion: on the clock edge after the final data byte is sampled, message is
//   updated and message_ready=1 for exactly one cycle (latency 1 clock from rx_valid).
//   Dropped (filtered) messages: no update, no pulse.
//  message holds its value between pulses; only changed on completion or reset.
//  NOTE_ON_ZERO_OFF=1 and type 9 with d2=00: message_type output = 8; stored running
//   status remains 9.
//  Back-to-back rx_valid every cycle is supported; no backpressure, no bytes lost.
//  rx_byte is ignored when rx_valid=0.
// TESTING
//  90 3C 64 -> one pulse, message={9,0,3C,64}, 1 clock after last byte.
//  90 3C 64 3E 00 (running status) -> pulses {9,0,3C,64} then {8,0,3E,00}.
//  B1 F8 07 FE 50 -> single pulse {B,1,07,50}; real-time bytes cause no effect.
//  C5 07 08 -> pulses {C,5,07,00} and {C,5,08,00}.
//  F0 7E 01 F7 40 -> no pulses; framing_error pulses once (for 40).
//  90 3C, reset_l=0 one cycle, then 64 -> no pulse, framing_error; OMNI=0,CHANNEL=2: 93 3C 64 -> no pulse.

Source files
------------

// File: rtl/midi_message_parser_if.sv
// MIDI byte-stream bus between the UART receiver and the message parser.
// Handshake: rx_valid is a one-cycle strobe. rx_byte is meaningful only while
// rx_valid=1. There is no ready signal, so the parser accepts one byte on every
// cycle in which rx_valid=1. On the output side, message_ready and
// framing_error are one-cycle pulses. message holds its value between pulses.
interface midi_message_parser_if;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [23:0] message;        // {message_type[3:0], channel[3:0], data_byte1, data_byte2}
  logic        message_ready;
  logic        framing_error;

  modport master (
    output rx_byte, rx_valid,
    input  message, message_ready, framing_error
  );

  modport slave (
    input  rx_byte, rx_valid,
    output message, message_ready, framing_error
  );
endinterface

// File: rtl/midi_message_parser.sv
// MIDI channel-message assembler. It handles running status, real-time bytes
// interleaved with other traffic, SysEx discard and an optional channel filter.
// Each completed channel message produces one message_ready pulse.
module midi_message_parser #(
  parameter bit       OMNI             = 1'b1,
  parameter bit [3:0] CHANNEL          = 4'd0,
  parameter bit       NOTE_ON_ZERO_OFF = 1'b1
) (
  input  logic                   clock_50_000_000,
  input  logic                   reset_l,
  midi_message_parser_if.slave   bus,
  output logic [1:0]             dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2,
    SYSEX   = 2'd3
  } state_t;

  state_t      state_q;
  logic [3:0]  rs_type_q;   // running status: message type nibble
  logic [3:0]  rs_chan_q;   // running status: channel nibble
  logic        rs_drop_q;   // running status belongs to a filtered channel
  logic [7:0]  d1_q;        // first data byte of a two-byte message
  logic [23:0] msg_q;
  logic        ready_q;
  logic        ferr_q;

  // Byte classification and the contents of a message that completes this cycle.
  logic        is_rt_d;
  logic        is_status_d;
  logic        is_chan_status_d;
  logic        one_byte_type_d;
  logic [7:0]  cplt_d1_d;
  logic [7:0]  cplt_d2_d;
  logic [3:0]  cplt_type_d;

  // Decode the incoming byte and form the output message for a completion.
  always_comb begin
    is_rt_d          = (bus.rx_byte >= 8'hF8);
    is_status_d      = bus.rx_byte[7];
    is_chan_status_d = bus.rx_byte[7] && (bus.rx_byte[7:4] != 4'hF);
    one_byte_type_d  = (rs_type_q == 4'hC) || (rs_type_q == 4'hD);
    cplt_d1_d        = (state_q == WAIT_D1) ? bus.rx_byte : d1_q;
    cplt_d2_d        = (state_q == WAIT_D1) ? 8'h00 : bus.rx_byte;
    // A velocity-0 note-on is reported as note-off. Running status stays note-on.
    if (NOTE_ON_ZERO_OFF && (rs_type_q == 4'h9) && (cplt_d2_d == 8'h00)) begin
      cplt_type_d = 4'h8;
    end else begin
      cplt_type_d = rs_type_q;
    end
  end

  // Parser FSM with registered message, pulse and running-status state.
  always_ff @(posedge clock_50_000_000) begin
    if (!reset_l) begin
      state_q   <= IDLE;
      rs_type_q <= 4'h0;
      rs_chan_q <= 4'h0;
      rs_drop_q <= 1'b0;
      d1_q      <= 8'h00;
      msg_q     <= 24'h0;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      if (bus.rx_valid && !is_rt_d) begin
        if (is_chan_status_d) begin
          // A new status abandons any partial message silently.
          rs_type_q <= bus.rx_byte[7:4];
          rs_chan_q <= bus.rx_byte[3:0];
          rs_drop_q <= !OMNI && (bus.rx_byte[3:0] != CHANNEL);
          state_q   <= WAIT_D1;
        end else if (is_status_d) begin
          // System common byte: running status is cancelled. F0 opens SysEx.
          rs_type_q <= 4'h0;
          rs_chan_q <= 4'h0;
          rs_drop_q <= 1'b0;
          state_q   <= (bus.rx_byte == 8'hF0) ? SYSEX : IDLE;
        end else begin
          case (state_q)
            IDLE: ferr_q <= 1'b1;
            WAIT_D1: begin
              if (one_byte_type_d) begin
                if (!rs_drop_q) begin
                  msg_q   <= {cplt_type_d, rs_chan_q, cplt_d1_d, cplt_d2_d};
                  ready_q <= 1'b1;
                end
              end else begin
                d1_q    <= bus.rx_byte;
                state_q <= WAIT_D2;
              end
            end
            WAIT_D2: begin
              if (!rs_drop_q) begin
                msg_q   <= {cplt_type_d, rs_chan_q, cplt_d1_d, cplt_d2_d};
                ready_q <= 1'b1;
              end
              state_q <= WAIT_D1;
            end
            default: ; // SYSEX: payload bytes are discarded
          endcase
        end
      end
    end
  end

  assign bus.message       = msg_q;
  assign bus.message_ready = ready_q;
  assign bus.framing_error = ferr_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_midi_message_parser.sv
// Bench for midi_message_parser. Two instances are driven with the same byte
// stream: an omni instance and one filtered to channel 2. A byte-level
// reference model predicts the pulses and the held message for both.
module tb_midi_message_parser;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #10 clk = ~clk;
  logic reset_l;

  midi_message_parser_if bus0 ();
  midi_message_parser_if bus1 ();
  logic [1:0] dbg0, dbg1;

  midi_message_parser #(.OMNI(1'b1), .CHANNEL(4'd0), .NOTE_ON_ZERO_OFF(1'b1)) dut0 (
    .clock_50_000_000(clk), .reset_l(reset_l), .bus(bus0.slave), .dbg_state_o(dbg0));
  midi_message_parser #(.OMNI(1'b0), .CHANNEL(4'd2), .NOTE_ON_ZERO_OFF(1'b1)) dut1 (
    .clock_50_000_000(clk), .reset_l(reset_l), .bus(bus1.slave), .dbg_state_o(dbg1));

  // ---------------- reference model ----------------
  int          m_rs   [2];  // running status byte, -1 when none
  bit          m_sx   [2];  // inside SysEx
  int          m_cnt  [2];  // data bytes collected for current message
  logic [7:0]  m_d1   [2];
  logic [23:0] m_msg  [2];  // expected held message
  bit          e_rdy  [2];
  bit          e_ferr [2];
  logic [23:0] exp_q [$];   // scoreboard for the omni instance

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_rs[k] = -1; m_sx[k] = 0; m_cnt[k] = 0; m_d1[k] = 8'h00;
      m_msg[k] = 24'h0; e_rdy[k] = 0; e_ferr[k] = 0;
    end
    exp_q.delete();
  endfunction

  function automatic void emit(int k, logic [7:0] d1, logic [7:0] d2);
    int typ;
    int chan;
    typ  = m_rs[k] / 16;
    chan = m_rs[k] % 16;
    if (k == 1 && chan != 2) return;
    if (typ == 9 && d2 == 8'h00) typ = 8;
    m_msg[k] = {typ[3:0], chan[3:0], d1, d2};
    e_rdy[k] = 1;
    if (k == 0) exp_q.push_back(m_msg[k]);
  endfunction

  function automatic void model_byte(int k, logic [7:0] b);
    int need;
    e_rdy[k] = 0;
    e_ferr[k] = 0;
    if (b >= 8'hF8) return;
    if (b >= 8'hF0) begin
      m_rs[k] = -1; m_sx[k] = (b == 8'hF0); m_cnt[k] = 0;
      return;
    end
    if (b >= 8'h80) begin
      m_rs[k] = int'(b); m_sx[k] = 0; m_cnt[k] = 0;
      return;
    end
    if (m_rs[k] < 0) begin
      e_ferr[k] = !m_sx[k];
      return;
    end
    need = (m_rs[k] / 16 == 12 || m_rs[k] / 16 == 13) ? 1 : 2;
    if (need == 1) emit(k, b, 8'h00);
    else if (m_cnt[k] == 0) begin
      m_d1[k] = b; m_cnt[k] = 1;
    end else begin
      emit(k, m_d1[k], b); m_cnt[k] = 0;
    end
  endfunction

  // ---------------- scoreboard / checks ----------------
  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("ready0", {23'h0, bus0.message_ready}, {23'h0, e_rdy[0]});
    chk("ferr0",  {23'h0, bus0.framing_error}, {23'h0, e_ferr[0]});
    chk("msg0",   bus0.message, m_msg[0]);
    chk("ready1", {23'h0, bus1.message_ready}, {23'h0, e_rdy[1]});
    chk("ferr1",  {23'h0, bus1.framing_error}, {23'h0, e_ferr[1]});
    chk("msg1",   bus1.message, m_msg[1]);
    if (bus0.message_ready === 1'b1) begin
      if (exp_q.size() == 0) chk("sb_unexpected", bus0.message, 24'hxxxxxx);
      else chk("sb_msg0", bus0.message, exp_q.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus0.rx_valid = 1'b1; bus0.rx_byte = b;
    bus1.rx_valid = 1'b1; bus1.rx_byte = b;
    model_byte(0, b);
    model_byte(1, b);
    @(posedge clk);
    #1;
    bus0.rx_valid = 1'b0; bus1.rx_valid = 1'b0;
    check_outputs();
  endtask

  task automatic idle_cycle();
    logic [7:0] junk;
    junk = 8'($urandom_range(0, 255));
    @(negedge clk);
    bus0.rx_valid = 1'b0; bus0.rx_byte = junk;
    bus1.rx_valid = 1'b0; bus1.rx_byte = junk;
    for (int k = 0; k < 2; k++) begin e_rdy[k] = 0; e_ferr[k] = 0; end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_l = 1'b0;
    bus0.rx_valid = 1'b0; bus1.rx_valid = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check_outputs();
    reset_l = 1'b1;
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 55)      return 8'($urandom_range(8'h00, 8'h7F));
    else if (r < 85) return 8'($urandom_range(8'h80, 8'hEF));
    else if (r < 93) return 8'($urandom_range(8'hF8, 8'hFF));
    else if (r < 96) return 8'hF0;
    else             return 8'($urandom_range(8'hF1, 8'hF7));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset_l = 1'b0;
    bus0.rx_valid = 1'b0; bus0.rx_byte = 8'h00;
    bus1.rx_valid = 1'b0; bus1.rx_byte = 8'h00;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outputs();
    reset_l = 1'b1;

    // Basic note-on, then running status with velocity-0 note-on.
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64); idle_cycle();
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
    send_byte(8'h3E); send_byte(8'h00); idle_cycle();
    // Real-time bytes interleaved in a control change.
    send_byte(8'hB1); send_byte(8'hF8); send_byte(8'h07);
    send_byte(8'hFE); send_byte(8'h50); idle_cycle();
    // One-data-byte program change with running status.
    send_byte(8'hC5); send_byte(8'h07); send_byte(8'h08); idle_cycle();
    // SysEx payload is silent, then a stray data byte gives a framing error.
    send_byte(8'hF0); send_byte(8'h7E); send_byte(8'h01);
    send_byte(8'hF7); send_byte(8'h40); idle_cycle();
    // Reset in mid-message discards the partial message.
    send_byte(8'h90); send_byte(8'h3C);
    apply_reset();
    send_byte(8'h64); idle_cycle();
    // Channel filter: channel 3 is dropped by the filtered instance, channel 2 is kept.
    send_byte(8'h93); send_byte(8'h3C); send_byte(8'h64);
    send_byte(8'h92); send_byte(8'h3C); send_byte(8'h64);
    // A new status abandons a partial message.
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h80);
    send_byte(8'h3C); send_byte(8'h40); idle_cycle();
    // Channel pressure on channel 2.
    send_byte(8'hD2); send_byte(8'h11); idle_cycle();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) apply_reset();
      else if ($urandom_range(0, 4) == 0) idle_cycle();
      else send_byte(rand_byte());
    end
    idle_cycle();

    chk("sb_left", 24'(exp_q.size()), 24'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
